// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier.
// State encodings and default widths live here so that the top level and the bench agree on them.
package mult_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cla_16b.sv
// Carry-lookahead adder built from 4-bit lookahead cells.
// Group generate/propagate terms feed a carry chain between the cells.
module cla_16b #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / 4;

  logic [NG:0] gc;

  assign gc[0] = cin;

  for (genvar i = 0; i < NG; i++) begin : g_cell
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;

    assign g = a[4*i +: 4] & b[4*i +: 4];
    assign p = a[4*i +: 4] ^ b[4*i +: 4];

    // Flattened lookahead: every carry depends only on g/p and the cell carry-in.
    assign c[0] = gc[i];
    assign c[1] = g[0] | (p[0] & gc[i]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[i]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & gc[i]);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign sum[4*i +: 4] = p ^ c;
    assign gc[i+1]       = grp_g | (grp_p & gc[i]);
  end

  assign cout = gc[NG];

endmodule

// File: rtl/seq_mult_16b.sv
// Radix-2 shift-and-add multiplier: one CLA add per cycle, WIDTH iterations per product.
// Signed operands are reduced to magnitudes up front and the sign is reapplied on DONE entry.
module seq_mult_16b
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CW-1:0]      count_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [2*WIDTH-1:0] product_d;

  // Iteration datapath: conditional add, then shift {cout, sum, mplier} right by one.
  assign addend = mplier_q[0] ? mcand_q : '0;

  cla_16b #(.WIDTH(WIDTH)) u_cla (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign acc_d     = {cout, sum[WIDTH-1:1]};
  assign mplier_d  = {sum[0], mplier_q[WIDTH-1:1]};
  assign product_d = cond_negate({acc_d, mplier_d}, neg_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            mcand_q  <= magnitude(a, signed_op);
            mplier_q <= magnitude(b, signed_op);
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            product_q <= product_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_16b.sv
// Bench for seq_mult_16b: a cycle-level behavioural model checked every cycle,
// plus directed literal expectations and randomized operands.
module tb_seq_mult_16b;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          signed_op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  seq_mult_16b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint px;
    longint py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return 32'(px * py);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since an accepted start; done lands WIDTH+1 cycles later.
  int          m_cnt = 0;
  logic [31:0] m_pend;
  logic [31:0] m_prod;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_prod = '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  = 1;
        m_pend = ref_prod(a, b, signed_op);
      end
    end else if (m_cnt == W + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == W + 1) m_prod = m_pend;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy",    64'(busy),    64'(m_cnt != 0));
      chk("cyc_done",    64'(done),    64'(m_cnt == W + 1));
      chk("cyc_product", 64'(product), 64'(m_prod));
    end
  end

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib, input logic s);
    @(negedge clk);
    a = ia; b = ib; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle offset from the start edge at which done was seen.
  task automatic wait_done(input string nm, output int at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    at = n + 1;
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end
  endtask

  task automatic run_count(input int n, output int nb, output int nd, output int first_at);
    nb = 0; nd = 0; first_at = -1;
    for (int i = 0; i < n; i++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin
        nd++;
        if (first_at < 0) first_at = i + 1;
      end
      @(negedge clk);
    end
  endtask

  typedef struct { logic [15:0] x; logic [15:0] y; logic s; logic [31:0] p; } vec_t;
  vec_t dirs[4] = '{
    '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
    '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1},
    '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
    '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000}
  };

  logic [15:0] corners[5] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF};

  initial begin
    int nb, nd, at, first, last;
    logic [15:0] rx, ry;
    logic rs;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy",    64'(busy),    64'(0));
    chk("reset_done",    64'(done),    64'(0));
    chk("reset_product", 64'(product), 64'(0));
    rst_n = 1'b1;

    launch(16'd3, 16'd5, 1'b0);
    run_count(20, nb, nd, at);
    chk("basic_busy_cycles", 64'(nb), 64'(17));
    chk("basic_done_count",  64'(nd), 64'(1));
    chk("basic_done_cycle",  64'(at), 64'(17));
    chk("basic_product",     64'(product), 64'h0F);

    foreach (dirs[i]) begin
      launch(dirs[i].x, dirs[i].y, dirs[i].s);
      wait_done("dir", at);
      chk("dir_product", 64'(product), 64'(dirs[i].p));
      chk("dir_latency", 64'(at), 64'(17));
    end

    // Starts during RUN and during DONE must both be ignored.
    @(negedge clk);
    a = 16'd7; b = 16'd9; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", at);
    chk("ign_product", 64'(product), 64'd63);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_count(22, nb, nd, at);
    chk("ign_extra_done", 64'(nd), 64'(0));
    chk("ign_extra_busy", 64'(nb), 64'(0));
    chk("ign_hold",       64'(product), 64'd63);

    // Reset pulse mid-operation.
    launch(16'h1234, 16'h5678, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy",    64'(busy),    64'(0));
    chk("midrst_done",    64'(done),    64'(0));
    chk("midrst_product", 64'(product), 64'(0));
    launch(16'd2, 16'd3, 1'b0);
    wait_done("postrst", at);
    chk("postrst_product", 64'(product), 64'd6);
    chk("postrst_latency", 64'(at), 64'(17));

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'd1000; b = 16'd1234; signed_op = 1'b0; start = 1'b1;
    nd = 0; first = -1; last = -1;
    for (int i = 1; i <= 54; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (first < 0) first = i;
        last = i;
        chk("b2b_product", 64'(product), 64'd1234000);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(nd), 64'(3));
    chk("b2b_first_done", 64'(first), 64'(17));
    chk("b2b_spacing",    64'(last - first), 64'(36));

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      rs = 1'($urandom);
      launch(rx, ry, rs);
      wait_done("rnd", at);
      chk("rnd_product", 64'(product), 64'(ref_prod(rx, ry, rs)));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
